axi_stream_slave_fifo: RTL and testbench
========================================

// Module: axi_stream_slave_fifo
// PURPOSE
// - Parametrised AXI-Stream ingress for the message-authentication datapath: accepts beats (data/keep/last)
//   from the system, buffers them in a DEPTH-entry FIFO and presents them to the hash/encrypt core.
// - Decouples system-side valid from core-side ready; carries packet framing the single-register slave lacks.
// PARAMETERS
// - DATA_WIDTH  512  beat width in bits; multiple of 8
// - DEPTH       4    FIFO entries; power of 2, >= 2
// - LEN_WIDTH   64   width of message byte-length counter (optional feature only)
// PORTS
// - clk            in   1              single clock, all logic on rising edge
// - reset          in   1              synchronous, active-high
// - s_valid        in   1              system beat valid
// - s_ready        out  1              slave can accept beat
// - s_data         in   DATA_WIDTH     system beat data
// - s_keep         in   DATA_WIDTH/8   byte enables, bit i -> byte i
// - s_last         in   1              final beat of message
// - m_valid        out  1              beat available to core
// - m_ready        in   1              core accepts beat
// - m_data         out  DATA_WIDTH     head beat data
// - m_keep         out  DATA_WIDTH/8   head beat keep
// - m_last         out  1              head beat last
// - fill_level     out  $clog2(DEPTH)+1  entries currently stored
// - msg_len        out  LEN_WIDTH      bytes in completed message (AXIS_SLV_MSG_LEN_EN only)
// - msg_len_valid  out  1              1-cycle strobe for msg_len (AXIS_SLV_MSG_LEN_EN only)
// BEHAVIOUR
// - Reset: s_ready=0 during reset, 1 first cycle after; m_valid=0, m_data/m_keep=0, m_last=0, fill_level=0,
//   pointers=0, msg_len=0, msg_len_valid=0. Reset mid-message flushes all stored beats and the length counter.
// - push = s_valid & s_ready; pop = m_valid & m_ready. s_ready = (fill_level != DEPTH), registered-count based;
//   no combinational path m_ready -> s_ready. When full, push blocked even if pop occurs same cycle.
// - Latency: beat pushed at edge N is on m_* with m_valid=1 after edge N (visible cycle N+1). m_* come from
//   registers/storage indexed by registered read pointer; stable while m_valid & !m_ready.
// - Simultaneous push+pop (not full, not empty): fill_level unchanged, both pointers advance.
// - Pop when empty impossible (m_valid=0); m_ready ignored. s_valid while full: beat held by source, no loss.
// - Pointers width $clog2(DEPTH), wrap DEPTH-1 -> 0; fill_level saturates logically at DEPTH (never exceeds).
// - Order preserved; keep/last stored per entry unchanged. No keep checking; keep passed through verbatim.
// CONFIGURATION
// - `AXIS_SLV_MSG_LEN_EN defined: byte counter adds popcount(s_keep) on every push; on push with s_last=1,
//   msg_len <= counter + popcount(s_keep), msg_len_valid=1 next cycle for exactly 1 cycle, counter <= 0.
//   Counter wraps modulo 2^LEN_WIDTH. Strobe timing is push-side (may precede last beat leaving FIFO).
// - Not defined: msg_len/msg_len_valid ports absent; no counter logic.
// STRUCTURE
// - Package axis_slv_pkg: localparam function keep_width(dw)=dw/8; typedef struct {data, keep, last} beat_t
//   parametrised via macros for DATA_WIDTH; popcount function for keep.
// - Sub-module axis_fifo_mem: DEPTH x beat_t storage, synchronous write, async read by pointer.
// - Top holds pointers, fill_level, handshake, optional length counter.
// TESTING (DATA_WIDTH=512, DEPTH=4)
// - Reset 3 cycles, release -> s_ready=1, m_valid=0, fill_level=0 next cycle.
// - Push 0xA5A5A5A5A5A5A5A5 with m_ready=0 -> m_valid=1 next cycle, m_data=0xA5..A5, fill_level=1.
// - Push 4 beats (0x1..0x4), m_ready=0 -> fill_level=4, s_ready=0; 5th beat 0x5 held; drain -> 1,2,3,4,5 in order.
// - Full FIFO, s_valid=1 and m_ready=1 same cycle -> only pop, fill_level 4->3, s_ready=1 next cycle.
// - Continuous s_valid=m_ready=1 for 20 beats -> 1 beat/cycle throughput, pointers wrap, fill_level stays 1.
// - MSG_LEN_EN: beats keep all-ones, all-ones, 0x0000_00FF(last) -> msg_len=136, msg_len_valid 1 cycle;
//   reset asserted after first beat of next message -> counter cleared, next 1-beat message reports its own length.

Source files
------------

// File: rtl/axi_stream_slave_fifo_pkg.sv
// Shared beat type, keep-width helper and keep popcount for the AXI-Stream ingress FIFO.
// Beat data width is fixed at compile time by AXIS_SLV_DATA_WIDTH (default 512).
`ifndef AXIS_SLV_DATA_WIDTH
`define AXIS_SLV_DATA_WIDTH 512
`endif

package axis_slv_pkg;

  function automatic int unsigned keep_width(input int unsigned dw);
    return dw / 8;
  endfunction

  localparam int unsigned DATA_W = `AXIS_SLV_DATA_WIDTH;
  localparam int unsigned KEEP_W = keep_width(DATA_W);
  localparam int unsigned CNT_W  = $clog2(KEEP_W + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  // Number of valid bytes in one beat
  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] keep);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      n = n + CNT_W'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_stream_slave_fifo_mem.sv
// DEPTH x beat_t storage: synchronous write, asynchronous read by pointer.
module axis_fifo_mem
  import axis_slv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  beat_t            wbeat,
  input  logic [PTR_W-1:0] raddr,
  output beat_t            rbeat
);

  beat_t mem_q [DEPTH];
  beat_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wbeat;
    end
  end

  // Cleared on reset so the head beat reads as zero while empty
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rbeat = mem_q[raddr];

endmodule

// File: rtl/axi_stream_slave_fifo.sv
// AXI-Stream ingress FIFO feeding the hash/encrypt core; holds pointers, fill level and handshake.
// Optional message byte-length reporting is enabled by defining AXIS_SLV_MSG_LEN_EN.
module axi_stream_slave_fifo
  import axis_slv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LEN_WIDTH  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic [DATA_WIDTH/8-1:0]    s_keep,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [DATA_WIDTH/8-1:0]    m_keep,
  output logic                       m_last,
`ifdef AXIS_SLV_MSG_LEN_EN
  output logic [LEN_WIDTH-1:0]       msg_len,
  output logic                       msg_len_valid,
`endif
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              push, pop;
  beat_t             wbeat, rbeat;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid_q & m_ready;

  assign wbeat.data = DATA_W'(s_data);
  assign wbeat.keep = KEEP_W'(s_keep);
  assign wbeat.last = s_last;

  axis_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wbeat (wbeat),
    .raddr (rd_ptr_q),
    .rbeat (rbeat)
  );

  // Pointer and occupancy update; ready/valid derive from the next count so they stay registered
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    fill_d    = fill_q + FILL_W'(push) - FILL_W'(pop);
    s_ready_d = (fill_d != FILL_W'(DEPTH));
    m_valid_d = (fill_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign fill_level = fill_q;
  assign m_data     = DATA_WIDTH'(rbeat.data);
  assign m_keep     = (DATA_WIDTH/8)'(rbeat.keep);
  assign m_last     = rbeat.last;

`ifdef AXIS_SLV_MSG_LEN_EN
  logic [LEN_WIDTH-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_WIDTH-1:0] msg_len_q, msg_len_d;
  logic                 msg_len_valid_q, msg_len_valid_d;
  logic [LEN_WIDTH-1:0] beat_bytes;

  assign beat_bytes = LEN_WIDTH'(popcount(KEEP_W'(s_keep)));

  // Byte accumulation on push; the last beat publishes the total and restarts the count
  always_comb begin
    len_cnt_d       = len_cnt_q;
    msg_len_d       = msg_len_q;
    msg_len_valid_d = 1'b0;
    if (push) begin
      if (s_last) begin
        msg_len_d       = len_cnt_q + beat_bytes;
        msg_len_valid_d = 1'b1;
        len_cnt_d       = '0;
      end else begin
        len_cnt_d = len_cnt_q + beat_bytes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_cnt_q       <= '0;
      msg_len_q       <= '0;
      msg_len_valid_q <= 1'b0;
    end else begin
      len_cnt_q       <= len_cnt_d;
      msg_len_q       <= msg_len_d;
      msg_len_valid_q <= msg_len_valid_d;
    end
  end

  assign msg_len       = msg_len_q;
  assign msg_len_valid = msg_len_valid_q;
`endif

endmodule

// File: tb/tb_axi_stream_slave_fifo.sv
// Scoreboard bench for axi_stream_slave_fifo: directed handshake cases plus random traffic.
// Length-report checks are compiled in when AXIS_SLV_MSG_LEN_EN is defined.
`timescale 1ns/1ps
module tb_axi_stream_slave_fifo;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int LW    = 64;
  localparam int BUDGET = 200;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [DW-1:0]            s_data = '0;
  logic [KW-1:0]            s_keep = '0;
  logic                     s_last = 1'b0;
  logic                     m_valid;
  logic                     m_ready = 1'b0;
  logic [DW-1:0]            m_data;
  logic [KW-1:0]            m_keep;
  logic                     m_last;
  logic [$clog2(DEPTH):0]   fill_level;
`ifdef AXIS_SLV_MSG_LEN_EN
  logic [LW-1:0]            msg_len;
  logic                     msg_len_valid;
  logic [LW-1:0]            len_q[$];
  logic [LW-1:0]            acc = '0;
`endif

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b0;

  axi_stream_slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_keep        (s_keep),
    .s_last        (s_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_keep        (m_keep),
    .m_last        (m_last),
`ifdef AXIS_SLV_MSG_LEN_EN
    .msg_len       (msg_len),
    .msg_len_valid (msg_len_valid),
`endif
    .fill_level    (fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Records each accepted beat (and its message length) as the expected output
  always @(negedge clk) begin
    #1;
    if (!reset && s_valid && s_ready) begin
      q.push_back('{data: s_data, keep: s_keep, last: s_last});
`ifdef AXIS_SLV_MSG_LEN_EN
      if (s_last) begin
        len_q.push_back(acc + LW'($countones(s_keep)));
        acc = '0;
      end else begin
        acc = acc + LW'($countones(s_keep));
      end
`endif
    end
  end

  // Output monitor: occupancy/handshake against the model, head beat against the scoreboard
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("fill_level", DW'(fill_level), DW'(q.size()));
      check("s_ready", DW'(s_ready), DW'(q.size() != DEPTH));
      check("m_valid", DW'(m_valid), DW'(q.size() != 0));
      if (m_valid) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", DW'(1), DW'(0));
        end else begin
          check("m_data", m_data, q[0].data);
          check("m_keep", DW'(m_keep), DW'(q[0].keep));
          check("m_last", DW'(m_last), DW'(q[0].last));
          if (m_ready) void'(q.pop_front());
        end
      end
`ifdef AXIS_SLV_MSG_LEN_EN
      check("msg_len_valid", DW'(msg_len_valid), DW'(len_q.size() != 0));
      if (msg_len_valid && len_q.size() != 0) begin
        check("msg_len", DW'(msg_len), DW'(len_q.pop_front()));
      end
`endif
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    if (n >= BUDGET) check("send_timeout", DW'(n), DW'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (fill_level != 0 && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    if (n >= BUDGET) check("drain_timeout", DW'(n), DW'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset = 1'b1;
    s_valid = 1'b0;
    q.delete();
`ifdef AXIS_SLV_MSG_LEN_EN
    len_q.delete();
    acc = '0;
`endif
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [DW-1:0] a5;
    a5 = {(DW/64){64'hA5A5_A5A5_A5A5_A5A5}};

    // Reset state
    do_reset(3);
    @(negedge clk);
    check("rst_s_ready", DW'(s_ready), DW'(1));
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_fill", DW'(fill_level), DW'(0));
    check("rst_m_data", m_data, DW'(0));
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single beat appears the cycle after the push
    m_ready = 1'b0;
    send(a5, '1, 1'b0);
    @(negedge clk);
    check("a5_m_valid", DW'(m_valid), DW'(1));
    check("a5_m_data", m_data, a5);
    check("a5_fill", DW'(fill_level), DW'(1));
    drain();

    // Fill to DEPTH, fifth beat held, full+pop same cycle pops only
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(DW'(i), '1, 1'b0);
    @(negedge clk);
    check("full_fill", DW'(fill_level), DW'(4));
    check("full_s_ready", DW'(s_ready), DW'(0));
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = DW'(5); s_keep = '1; s_last = 1'b1;
    repeat (3) @(negedge clk);
    check("held_fill", DW'(fill_level), DW'(4));
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("fullpop_fill", DW'(fill_level), DW'(3));
    check("fullpop_s_ready", DW'(s_ready), DW'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain();

    // Streaming at one beat per cycle
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = rand_data(); s_keep = '1; s_last = (i == 19);
      @(negedge clk);
      check("stream_s_ready", DW'(s_ready), DW'(1));
      if (i > 0) check("stream_fill", DW'(fill_level), DW'(1));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      m_ready = ($urandom_range(0, 9) < 6);
      s_data  = rand_data();
      s_keep  = {$urandom, $urandom};
      s_last  = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain();

`ifdef AXIS_SLV_MSG_LEN_EN
    // Length report: 64 + 64 + 8 bytes
    m_ready = 1'b1;
    send(rand_data(), '1, 1'b0);
    send(rand_data(), '1, 1'b0);
    send(rand_data(), KW'(64'h0000_00FF), 1'b1);
    @(negedge clk);
    check("len136_valid", DW'(msg_len_valid), DW'(1));
    check("len136", DW'(msg_len), DW'(136));
    @(negedge clk);
    check("len136_strobe_1cyc", DW'(msg_len_valid), DW'(0));
    drain();

    // Reset mid-message clears the partial count
    send(rand_data(), '1, 1'b0);
    do_reset(2);
    mon_en = 1'b1;
    m_ready = 1'b1;
    send(rand_data(), KW'(64'h0F), 1'b1);
    @(negedge clk);
    check("len_after_rst_valid", DW'(msg_len_valid), DW'(1));
    check("len_after_rst", DW'(msg_len), DW'(4));
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
